// File: rtl/dac_sample_sequencer_if.sv
// rtl/dac_sample_sequencer_if.sv - sample stream and SPI transmitter handshake bundle
// Slave side is the sequencer: it consumes samples and drives the transmitter start/word.
interface dac_sample_sequencer_if;
  logic [11:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        spi_busy;
  logic        tx_start;
  logic [15:0] tx_data;

  modport master (
    output s_data, s_valid, spi_busy,
    input  s_ready, tx_start, tx_data
  );

  modport slave (
    input  s_data, s_valid, spi_busy,
    output s_ready, tx_start, tx_data
  );
endinterface

// File: rtl/dac_sample_sequencer.sv
// rtl/dac_sample_sequencer.sv - fixed-rate MCP4821 command sequencer with sample FIFO
// Optional saturating underrun counter enabled by DAC_SEQ_UNDERRUN_CNT_EN.
module dac_sample_sequencer #(
  parameter int SAMPLE_PERIOD_CLK_CYCLES = 1000,
  parameter int FIFO_DEPTH               = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         gain_2x,
  input  logic                         shutdown,
  dac_sample_sequencer_if.slave        bus,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         underrun,
  output logic                         late,
  output logic [7:0]                   underrun_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SAMPLE_PERIOD_CLK_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_PERIOD_CLK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic          pending;
  logic          pending_next;
  logic          pop;
  logic          push;
  logic          empty;
  logic          full_next;
  logic          underrun_next;
  logic          s_ready_q;
  logic [15:0]   tx_data_q;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   wr_ptr_next;
  logic [AW:0]   rd_ptr_next;
  logic [11:0]   mem [FIFO_DEPTH];

  // Tick generator: counter is held at zero whenever the sequencer is not enabled.
  assign tick = enable && (tick_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (!enable || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_ONE;
    end
  end

  assign empty       = (wr_ptr == rd_ptr);
  assign push        = bus.s_valid && s_ready_q;
  assign wr_ptr_next = push ? (wr_ptr + PTR_ONE) : wr_ptr;
  assign rd_ptr_next = pop  ? (rd_ptr + PTR_ONE) : rd_ptr;
  assign full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                       (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
  assign fifo_level  = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= bus.s_data;
    end
  end

  // s_ready is registered from the next-cycle full flag so it tracks !full exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      s_ready_q <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      s_ready_q <= !full_next;
    end
  end

  always_comb begin
    state_next    = state;
    pending_next  = pending;
    pop           = 1'b0;
    underrun_next = 1'b0;
    if (tick && (state != IDLE)) begin
      pending_next = 1'b1;
    end
    case (state)
      IDLE: begin
        if (tick || pending) begin
          pending_next = 1'b0;
          if (empty) begin
            underrun_next = 1'b1;
          end else begin
            pop        = 1'b1;
            state_next = LAUNCH;
          end
        end
      end
      LAUNCH:    state_next = WAIT_BUSY;
      WAIT_BUSY: if (bus.spi_busy) state_next = WAIT_DONE;
      WAIT_DONE: if (!bus.spi_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= 1'b0;
      underrun  <= 1'b0;
      late      <= 1'b0;
      tx_data_q <= 16'h3000;
    end else begin
      state    <= state_next;
      pending  <= pending_next;
      underrun <= underrun_next;
      late     <= tick && pending;
      if (pop) begin
        tx_data_q <= {1'b0, 1'b0, ~gain_2x, ~shutdown, mem[rd_ptr[AW-1:0]]};
      end
    end
  end

  assign bus.tx_start = (state == LAUNCH);
  assign bus.tx_data  = tx_data_q;
  assign bus.s_ready  = s_ready_q;

`ifdef DAC_SEQ_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt_q <= 8'h00;
    end else if (underrun && (underrun_cnt_q != 8'hFF)) begin
      underrun_cnt_q <= underrun_cnt_q + 8'h01;
    end
  end

  assign underrun_count = underrun_cnt_q;
`else
  assign underrun_count = 8'h00;
`endif

endmodule
